// File: rtl/word_serializer_pkg.sv
// Shared types for the word serializer: FSM state encoding and counter sizing.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    // Bit-counter width for a word of data_w bits; never narrower than one bit.
    function automatic int cnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/word_serializer_skid_hold_reg.sv
// One-entry holding buffer for the word serializer: load a word, take it back out.
module word_serializer_skid_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              take,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              full
);

    logic [DATA_W-1:0] data_r;
    logic              full_r;

    // Holding register and its occupancy flag; load and take never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= {DATA_W{1'b0}};
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= d;
            full_r <= 1'b1;
        end else if (take) begin
            full_r <= 1'b0;
        end
    end

    assign q    = data_r;
    assign full = full_r;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial word feeder, MSB first, with first/last markers and gapless streaming.
// Optional trailing even-parity bit per word when WORD_SERIALIZER_PARITY_EN is defined.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              dout_first,
    output logic              dout_last,
    input  logic              dout_ready
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    ser_state_e        state_r, state_nxt_s;
    logic [DATA_W-1:0] sh_r, sh_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;

    logic              hold_full_s;
    logic [DATA_W-1:0] hold_data_s;
    logic              hold_load_s;
    logic              hold_take_s;

    logic              accept_s;
    logic              consume_s;
    logic              end_s;
    logic              bypass_s;

    logic              dout_r, dout_valid_r, dout_first_r, dout_last_r;
    logic              dout_nxt_s, dout_valid_nxt_s, dout_first_nxt_s, dout_last_nxt_s;

`ifdef WORD_SERIALIZER_PARITY_EN
    logic              par_r, par_nxt_s;

    function automatic logic even_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
`endif

    word_serializer_skid_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load_s),
        .take  (hold_take_s),
        .d     (din),
        .q     (hold_data_s),
        .full  (hold_full_s)
    );

    assign din_ready = ~hold_full_s;
    assign accept_s  = din_valid & ~hold_full_s;
    assign consume_s = dout_valid_r & dout_ready;

    // Next-state, shifter, counter and holding-buffer control.
    always_comb begin
        state_nxt_s = state_r;
        sh_nxt_s    = sh_r;
        cnt_nxt_s   = cnt_r;
        hold_load_s = 1'b0;
        hold_take_s = 1'b0;
        end_s       = 1'b0;
        bypass_s    = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        par_nxt_s   = par_r;
`endif

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    sh_nxt_s    = din;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = SHIFT;
`ifdef WORD_SERIALIZER_PARITY_EN
                    par_nxt_s   = even_parity(din);
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (consume_s && (cnt_r == LAST_CNT)) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                    state_nxt_s = PARITY;
`else
                    end_s       = 1'b1;
`endif
                end else if (consume_s) begin
                    sh_nxt_s  = {sh_r[DATA_W-2:0], 1'b0};
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            PARITY: begin
                if (consume_s) begin
                    end_s = 1'b1;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Word end: a buffered word wins over a same-cycle bypass of din.
        if (end_s && hold_full_s) begin
            hold_take_s = 1'b1;
            sh_nxt_s    = hold_data_s;
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = SHIFT;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_nxt_s   = even_parity(hold_data_s);
`endif
        end else if (end_s && accept_s) begin
            bypass_s    = 1'b1;
            sh_nxt_s    = din;
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = SHIFT;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_nxt_s   = even_parity(din);
`endif
        end else if (end_s) begin
            state_nxt_s = IDLE;
        end else begin
            bypass_s = 1'b0;
        end

        if (accept_s && (state_r != IDLE) && !bypass_s) begin
            hold_load_s = 1'b1;
        end else begin
            hold_load_s = 1'b0;
        end
    end

    // Output decode from the next state so the ports can be driven from flops.
    always_comb begin
        dout_nxt_s       = 1'b0;
        dout_valid_nxt_s = 1'b0;
        dout_first_nxt_s = 1'b0;
        dout_last_nxt_s  = 1'b0;
        case (state_nxt_s)
            SHIFT: begin
                dout_nxt_s       = sh_nxt_s[DATA_W-1];
                dout_valid_nxt_s = 1'b1;
                dout_first_nxt_s = (cnt_nxt_s == {CNT_W{1'b0}});
`ifdef WORD_SERIALIZER_PARITY_EN
                dout_last_nxt_s  = 1'b0;
`else
                dout_last_nxt_s  = (cnt_nxt_s == LAST_CNT);
`endif
            end
            PARITY: begin
`ifdef WORD_SERIALIZER_PARITY_EN
                dout_nxt_s       = par_nxt_s;
`else
                dout_nxt_s       = 1'b0;
`endif
                dout_valid_nxt_s = 1'b1;
                dout_first_nxt_s = 1'b0;
                dout_last_nxt_s  = 1'b1;
            end
            default: begin
                dout_nxt_s       = 1'b0;
                dout_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, shifter, counter and registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            sh_r         <= {DATA_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            dout_first_r <= 1'b0;
            dout_last_r  <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_r        <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            sh_r         <= sh_nxt_s;
            cnt_r        <= cnt_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            dout_first_r <= dout_first_nxt_s;
            dout_last_r  <= dout_last_nxt_s;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_r        <= par_nxt_s;
`endif
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_first = dout_first_r;
    assign dout_last  = dout_last_r;

endmodule
